// File: rtl/alu_decode_pkg.sv
// Shared types for the ALU decode stage: ALU control codes, RV32I opcodes,
// the decoded bundle carried through the skid buffer, and the buffer state.
package alu_decode_pkg;

  localparam int XLEN = 32;

  // ALU control codes understood by the execute-stage ALU
  typedef enum logic [4:0] {
    IADD = 5'd0,
    ISUB = 5'd1,
    IAND = 5'd2,
    IOR  = 5'd3,
    IXOR = 5'd4,
    ILT  = 5'd5,
    ILTU = 5'd6,
    IGE  = 5'd7,
    IGEU = 5'd8,
    IPAS = 5'd9,
    IEQ  = 5'd10,
    INE  = 5'd11
  } alu_op_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Decoded instruction bundle
  typedef struct packed {
    alu_op_e          alu_op;
    logic             sel_a_pc;
    logic             sel_b_imm;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             rd_we;
    logic             is_branch;
    logic             is_jump;
    logic             is_load;
    logic             is_store;
    logic             illegal;
  } dec_t;

  // Skid-buffer occupancy, encoded as {skid_valid, main_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I instruction word -> decoded ALU bundle.
module alu_decode_comb
  import alu_decode_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode/funct decode; anything this ALU cannot execute collapses to a clean illegal bundle
  always_comb begin
    logic legal;
    legal         = 1'b1;
    dec           = '0;
    dec.alu_op    = IADD;
    dec.rs1       = instr[19:15];
    dec.rs2       = instr[24:20];
    dec.rd        = instr[11:7];
    // every listed opcode ends in 2'b11, so compressed encodings fall to default
    case (opcode)
      OPC_OP_IMM: begin
        dec.imm       = imm_i;
        dec.sel_b_imm = 1'b1;
        dec.rd_we     = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = IADD;
          3'b010:  dec.alu_op = ILT;
          3'b011:  dec.alu_op = ILTU;
          3'b100:  dec.alu_op = IXOR;
          3'b110:  dec.alu_op = IOR;
          3'b111:  dec.alu_op = IAND;
          default: legal = 1'b0;  // shifts: no shifter in the ALU
        endcase
      end
      OPC_OP: begin
        dec.rd_we = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alu_op = IADD;
            3'b010:  dec.alu_op = ILT;
            3'b011:  dec.alu_op = ILTU;
            3'b100:  dec.alu_op = IXOR;
            3'b110:  dec.alu_op = IOR;
            3'b111:  dec.alu_op = IAND;
            default: legal = 1'b0;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.alu_op = ISUB;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec.alu_op    = IPAS;
        dec.imm       = imm_u;
        dec.sel_b_imm = 1'b1;
        dec.rd_we     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        dec.rd_we     = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = IEQ;
          3'b001:  dec.alu_op = INE;
          3'b100:  dec.alu_op = ILT;
          3'b101:  dec.alu_op = IGE;
          3'b110:  dec.alu_op = ILTU;
          3'b111:  dec.alu_op = IGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.imm       = imm_i;
        dec.sel_b_imm = 1'b1;
        dec.is_load   = 1'b1;
        dec.rd_we     = 1'b1;
      end
      OPC_STORE: begin
        dec.imm       = imm_s;
        dec.sel_b_imm = 1'b1;
        dec.is_store  = 1'b1;
      end
      OPC_JAL: begin
        dec.imm       = imm_j;
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        dec.is_jump   = 1'b1;
        dec.rd_we     = 1'b1;
      end
      OPC_JALR: begin
        dec.imm       = imm_i;
        dec.sel_b_imm = 1'b1;
        dec.is_jump   = 1'b1;
        dec.rd_we     = 1'b1;
        if (f3 != 3'b000) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec.alu_op    = IADD;
      dec.imm       = '0;
      dec.sel_a_pc  = 1'b0;
      dec.sel_b_imm = 1'b0;
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.illegal   = 1'b1;
    end
    // x0 is never written
    if (dec.rd == 5'd0) dec.rd_we = 1'b0;
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage between fetch and the ALU operand muxes: decodes each accepted
// word and presents it registered through a 2-entry skid buffer.
//
// Handshake: a word moves in when in_valid & in_ready, and out when
// out_valid & out_ready. in_ready depends only on registered state (no
// combinational path from out_ready); out_valid and all payload outputs are
// held stable while out_valid=1 and out_ready=0.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN_P-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] out_pc,
  output logic [4:0]        alu_op,
  output logic              sel_a_pc,
  output logic              sel_b_imm,
  output logic [XLEN_P-1:0] imm,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic              rd_we,
  output logic              is_branch,
  output logic              is_jump,
  output logic              is_load,
  output logic              is_store,
  output logic              illegal
);

  state_e            state_q;
  state_e            state_d;
  dec_t              dec_in;
  dec_t              main_q;
  dec_t              skid_q;
  logic [XLEN_P-1:0] main_pc_q;
  logic [XLEN_P-1:0] skid_pc_q;
  logic              in_xfer;
  logic              out_xfer;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  alu_decode_comb u_dec (
    .instr (instr),
    .dec   (dec_in)
  );

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next occupancy and which register loads from where; flush overrides all
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State and payload registers; reset clears payload so alu_op reads IADD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      main_pc_q <= '0;
      skid_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q    <= dec_in;
        main_pc_q <= pc;
      end else if (load_main_skid) begin
        main_q    <= skid_q;
        main_pc_q <= skid_pc_q;
      end
      if (load_skid) begin
        skid_q    <= dec_in;
        skid_pc_q <= pc;
      end
    end
  end

  assign out_pc    = main_pc_q;
  assign alu_op    = main_q.alu_op;
  assign sel_a_pc  = main_q.sel_a_pc;
  assign sel_b_imm = main_q.sel_b_imm;
  assign imm       = main_q.imm;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;
  assign rd_we     = main_q.rd_we;
  assign is_branch = main_q.is_branch;
  assign is_jump   = main_q.is_jump;
  assign is_load   = main_q.is_load;
  assign is_store  = main_q.is_store;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table streamed back-to-back,
// then hand-written stall/drain, flush and reset sequences.
module tb_alu_decode_stage;
  import alu_decode_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  alu_op;
  logic        sel_a_pc;
  logic        sel_b_imm;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        rd_we;
  logic        is_branch;
  logic        is_jump;
  logic        is_load;
  logic        is_store;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .alu_op    (alu_op),
    .sel_a_pc  (sel_a_pc),
    .sel_b_imm (sel_b_imm),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .rd_we     (rd_we),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_load   (is_load),
    .is_store  (is_store),
    .illegal   (illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {sel_a_pc, sel_b_imm, rd_we, is_branch, is_jump, is_load, is_store, illegal}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] imm;
    logic [14:0] regs;  // {rs1, rs2, rd}
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input logic [31:0] exp_pc);
    check({v.name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, " out_pc"}, out_pc, exp_pc);
    check({v.name, " alu_op"}, {27'd0, alu_op}, {27'd0, v.op});
    check({v.name, " imm"}, imm, v.imm);
    check({v.name, " regs"}, {17'd0, rs1, rs2, rd}, {17'd0, v.regs});
    check({v.name, " flags"},
          {24'd0, sel_a_pc, sel_b_imm, rd_we, is_branch, is_jump, is_load, is_store, illegal},
          {24'd0, v.flags});
  endtask

  // driver: present a word (or idle) for the coming rising edge
  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p);
    in_valid = v;
    instr    = w;
    pc       = p;
  endtask

  initial begin
    vecs[0]  = '{"addi",  32'hFFB00093, IADD, 32'hFFFFFFFB, {5'd0, 5'd27, 5'd1},  8'b0110_0000};
    vecs[1]  = '{"sub",   32'h402081B3, ISUB, 32'h00000000, {5'd1, 5'd2, 5'd3},   8'b0010_0000};
    vecs[2]  = '{"sll",   32'h002091B3, IADD, 32'h00000000, {5'd1, 5'd2, 5'd3},   8'b0000_0001};
    vecs[3]  = '{"bgeu",  32'hFE20FCE3, IGEU, 32'hFFFFFFF8, {5'd1, 5'd2, 5'd25},  8'b0001_0000};
    vecs[4]  = '{"lui",   32'h123452B7, IPAS, 32'h12345000, {5'd8, 5'd3, 5'd5},   8'b0110_0000};
    vecs[5]  = '{"auipc", 32'h00001017, IADD, 32'h00001000, {5'd0, 5'd0, 5'd0},   8'b1100_0000};
    vecs[6]  = '{"lw",    32'h00812303, IADD, 32'h00000008, {5'd2, 5'd8, 5'd6},   8'b0110_0100};
    vecs[7]  = '{"sw",    32'hFE712E23, IADD, 32'hFFFFFFFC, {5'd2, 5'd7, 5'd28},  8'b0100_0010};
    vecs[8]  = '{"jal",   32'h010000EF, IADD, 32'h00000010, {5'd0, 5'd16, 5'd1},  8'b1110_1000};
    vecs[9]  = '{"xori",  32'h7FF4C413, IXOR, 32'h000007FF, {5'd9, 5'd31, 5'd8},  8'b0110_0000};
    vecs[10] = '{"zero",  32'h00000000, IADD, 32'h00000000, {5'd0, 5'd0, 5'd0},   8'b0000_0001};
    vecs[11] = '{"br010", 32'h0020A063, IADD, 32'h00000000, {5'd1, 5'd2, 5'd0},   8'b0000_0001};
    vecs[12] = '{"jalr",  32'h00008067, IADD, 32'h00000000, {5'd1, 5'd0, 5'd0},   8'b0100_1000};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst alu_op", {27'd0, alu_op}, {27'd0, IADD});
    check("rst imm", imm, 32'd0);
    check("rst out_pc", out_pc, 32'd0);

    // decode table streamed one per cycle: each vector shows up the next cycle
    out_ready = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      if (i > 0) check_vec(vecs[i-1], 32'h1000 + 32'(4 * (i - 1)));
      if (i < 13) drive(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i));
      else drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
    end
    check("idle out_valid", {31'd0, out_valid}, 32'd0);

    // stall: three words offered with out_ready=0, only two fit
    out_ready = 1'b0;
    drive(1'b1, vecs[1].instr, 32'h2000);
    check("fill0 in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(32'h2000);
    @(negedge clk);
    drive(1'b1, vecs[3].instr, 32'h2004);
    check("fill1 in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(32'h2004);
    @(negedge clk);
    drive(1'b1, vecs[4].instr, 32'h2008);
    check("full in_ready", {31'd0, in_ready}, 32'd0);
    check("full hold pc", out_pc, 32'h2000);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    check("stall hold pc", out_pc, 32'h2000);
    check("stall hold op", {27'd0, alu_op}, {27'd0, ISUB});
    out_ready = 1'b1;
    // drain: scoreboard pops in order, bounded cycle budget
    for (int c = 0; c < 6 && exp_q.size() > 0; c++) begin
      if (out_valid) check("drain pc", out_pc, exp_q.pop_front());
      @(negedge clk);
    end
    check("drain leftover", 32'(exp_q.size()), 32'd0);
    check("drain empty", {31'd0, out_valid}, 32'd0);

    // flush in FULL: buffer emptied, offered word dropped
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, 32'h3000);
    @(negedge clk);
    drive(1'b1, vecs[1].instr, 32'h3004);
    @(negedge clk);
    drive(1'b1, vecs[2].instr, 32'h3008);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush full out_valid", {31'd0, out_valid}, 32'd0);
    check("flush full in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush full stays empty", {31'd0, out_valid}, 32'd0);
    end

    // flush in ONE while in_ready=1: the offered word must not be taken
    out_ready = 1'b0;
    drive(1'b1, vecs[6].instr, 32'h4000);
    @(negedge clk);
    drive(1'b1, vecs[7].instr, 32'h4004);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    check("flush one out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("flush one no emerge", {31'd0, out_valid}, 32'd0);

    // reset mid-stream while a bundle is held
    out_ready = 1'b0;
    drive(1'b1, vecs[3].instr, 32'h5000);
    @(negedge clk);
    check("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
    check("pre-rst alu_op", {27'd0, alu_op}, {27'd0, IGEU});
    drive(1'b1, vecs[1].instr, 32'h5004);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst alu_op", {27'd0, alu_op}, {27'd0, IADD});
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd1);
    check("mid-rst is_branch", {31'd0, is_branch}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
